// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM encoding and the flag bundle.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_SLL  = 4'd10;
    localparam logic [3:0] OP_SRL  = 4'd11;
    localparam logic [3:0] OP_SRA  = 4'd12;
    localparam logic [3:0] OP_RSVD = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic carryout;
        logic overflow;
        logic zero;
    } alu_flags_t;

    localparam alu_flags_t FLAGS_RESET = '{carryout: 1'b0, overflow: 1'b0, zero: 1'b1};

endpackage

// File: rtl/alu_comb_core.sv
// Combinational ALU core: result and flags for every single-cycle opcode.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [3:0]       command,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;
    logic             w_less;
    logic [SHW-1:0]   w_amt;

    // Every opcode except ADD uses A+~B+1, so SLT and SLTU share the subtractor.
    assign w_sub   = (command != OP_ADD);
    assign w_b_eff = w_sub ? ~operandB : operandB;
    assign {w_cout, w_sum} = {1'b0, operandA} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
    assign w_ovf   = w_cout ^ (w_sum[WIDTH-1] ^ operandA[WIDTH-1] ^ w_b_eff[WIDTH-1]);
    assign w_less  = w_sum[WIDTH-1] ^ w_ovf;
    assign w_amt   = operandB[SHW-1:0];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
        result   = '0;
        carryout = 1'b0;
        overflow = 1'b0;
        case (command)
            OP_ADD, OP_SUB: begin
                result   = w_sum;
                carryout = w_cout;
                overflow = w_ovf;
            end
            OP_XOR:  result = operandA ^ operandB;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, w_less};
            OP_AND:  result = operandA & operandB;
            OP_NAND: result = ~(operandA & operandB);
            OP_NOR:  result = ~(operandA | operandB);
            OP_OR:   result = operandA | operandB;
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, ~w_cout};
            OP_SLL:  result = operandA << w_amt;
            OP_SRL:  result = operandA >> w_amt;
            OP_SRA:  result = $unsigned($signed(operandA) >>> w_amt);
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake and an iterative shift-add multiplier.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       command,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    state_e           r_state;
    state_e           w_next_state;
    logic [WIDTH-1:0] r_mul_a;
    logic [WIDTH-1:0] r_mul_b;
    logic [WIDTH-1:0] r_acc;
    logic [SHW-1:0]   r_count;
    logic [WIDTH-1:0] r_result;
    alu_flags_t       r_flags;

    logic             w_accept;
    logic             w_take_mul;
    logic             w_mul_done;
    logic [3:0]       w_core_cmd;
    logic [WIDTH-1:0] w_core_a;
    logic [WIDTH-1:0] w_core_b;
    logic [WIDTH-1:0] w_core_result;
    logic             w_core_c;
    logic             w_core_o;
    logic             w_core_z;
    logic [WIDTH-1:0] w_acc_next;

    assign w_accept   = in_valid & in_ready;
    assign w_take_mul = w_accept & (command == OP_MUL);
    assign w_mul_done = (r_state == S_MUL) && (r_count == LAST_ITER);

    // While multiplying, the core is borrowed as the partial-sum adder.
    assign w_core_cmd = (r_state == S_MUL) ? OP_ADD  : command;
    assign w_core_a   = (r_state == S_MUL) ? r_acc   : operandA;
    assign w_core_b   = (r_state == S_MUL) ? r_mul_a : operandB;

    alu_comb_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .command  (w_core_cmd),
        .operandA (w_core_a),
        .operandB (w_core_b),
        .result   (w_core_result),
        .carryout (w_core_c),
        .overflow (w_core_o),
        .zero     (w_core_z)
    );

    assign w_acc_next = r_mul_b[0] ? w_core_result : r_acc;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_MUL: if (w_mul_done) w_next_state = S_DONE;
            default: begin
                if (w_accept)                            w_next_state = w_take_mul ? S_MUL : S_DONE;
                else if (r_state == S_DONE && !out_ready) w_next_state = S_DONE;
                else                                     w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: in_ready = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_acc   <= '0;
            r_count <= '0;
        end else if (w_take_mul) begin
            r_mul_a <= operandA;
            r_mul_b <= operandB;
            r_acc   <= '0;
            r_count <= '0;
        end else if (r_state == S_MUL) begin
            r_acc   <= w_acc_next;
            r_mul_a <= r_mul_a << 1;
            r_mul_b <= r_mul_b >> 1;
            r_count <= r_count + SHW'(1);
        end
    end

    // Output registers change only on capture, which keeps them stable while DONE is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_flags  <= FLAGS_RESET;
        end else if (w_accept && !w_take_mul) begin
            r_result <= w_core_result;
            r_flags  <= '{carryout: w_core_c, overflow: w_core_o, zero: w_core_z};
        end else if (w_mul_done) begin
            r_result <= w_acc_next;
            r_flags  <= '{carryout: 1'b0, overflow: 1'b0, zero: (w_acc_next == '0)};
        end
    end

    assign result   = r_result;
    assign carryout = r_flags.carryout;
    assign overflow = r_flags.overflow;
    assign zero     = r_flags.zero;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: a 32-bit and an 8-bit instance share clock and reset.
module tb_seq_alu;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t sb32[$];
    exp_t sb8[$];

    logic        s32_in_valid, s32_in_ready, s32_out_valid, s32_out_ready;
    logic [3:0]  s32_cmd;
    logic [31:0] s32_a, s32_b, s32_result;
    logic        s32_c, s32_o, s32_z;

    logic        s8_in_valid, s8_in_ready, s8_out_valid, s8_out_ready;
    logic [3:0]  s8_cmd;
    logic [7:0]  s8_a, s8_b, s8_result;
    logic        s8_c, s8_o, s8_z;

    seq_alu #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(s32_in_valid), .in_ready(s32_in_ready),
        .command(s32_cmd), .operandA(s32_a), .operandB(s32_b), .out_valid(s32_out_valid),
        .out_ready(s32_out_ready), .result(s32_result), .carryout(s32_c), .overflow(s32_o), .zero(s32_z)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(s8_in_valid), .in_ready(s8_in_ready),
        .command(s8_cmd), .operandA(s8_a), .operandB(s8_b), .out_valid(s8_out_valid),
        .out_ready(s8_out_ready), .result(s8_result), .carryout(s8_c), .overflow(s8_o), .zero(s8_z)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    // Reference model written from the arithmetic definitions, at width w (w <= 32).
    function automatic exp_t model(input int w, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] mask, full, s, aa, bb;
        longint      sa, sb;
        int          amt;
        aa   = 64'(a);
        bb   = 64'(b);
        mask = (64'd1 << w) - 64'd1;
        sa   = a[w-1] ? longint'(aa) - (longint'(1) << w) : longint'(aa);
        sb   = b[w-1] ? longint'(bb) - (longint'(1) << w) : longint'(bb);
        amt  = int'(b) & (w - 1);
        e.c  = 1'b0;
        e.o  = 1'b0;
        full = '0;
        case (cmd)
            OP_ADD: begin
                full = aa + bb;
                e.c  = full[w];
                s    = full & mask;
                e.o  = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
            end
            OP_SUB: begin
                full = aa + (~bb & mask) + 64'd1;
                e.c  = full[w];
                s    = full & mask;
                e.o  = (a[w-1] != b[w-1]) && (s[w-1] != a[w-1]);
            end
            OP_XOR:  s = aa ^ bb;
            OP_SLT:  s = (sa < sb) ? 64'd1 : 64'd0;
            OP_AND:  s = aa & bb;
            OP_NAND: s = ~(aa & bb) & mask;
            OP_NOR:  s = ~(aa | bb) & mask;
            OP_OR:   s = aa | bb;
            OP_SLTU: s = (aa < bb) ? 64'd1 : 64'd0;
            OP_MUL:  s = (aa * bb) & mask;
            OP_SLL:  s = (aa << amt) & mask;
            OP_SRL:  s = aa >> amt;
            OP_SRA:  s = 64'(sa >>> amt) & mask;
            default: s = '0;
        endcase
        e.res = s[31:0];
        e.z   = (s == 64'd0);
        return e;
    endfunction

    task automatic issue32(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        s32_in_valid = 1'b1; s32_cmd = cmd; s32_a = a; s32_b = b;
        while (s32_in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) begin
            checks++; failures++;
            $display("FAIL issue32_timeout: in_ready=%b after %0d cycles, want 1", s32_in_ready, n);
        end else begin
            sb32.push_back(model(32, cmd, a, b));
        end
        @(posedge clk); #1;
        s32_in_valid = 1'b0;
    endtask

    task automatic issue8(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        s8_in_valid = 1'b1; s8_cmd = cmd; s8_a = a; s8_b = b;
        while (s8_in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) begin
            checks++; failures++;
            $display("FAIL issue8_timeout: in_ready=%b after %0d cycles, want 1", s8_in_ready, n);
        end else begin
            sb8.push_back(model(8, cmd, 32'(a), 32'(b)));
        end
        @(posedge clk); #1;
        s8_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s32_in_valid = 1'b0; s32_out_ready = 1'b0; s32_cmd = '0; s32_a = '0; s32_b = '0;
        s8_in_valid  = 1'b0; s8_out_ready  = 1'b0; s8_cmd  = '0; s8_a  = '0; s8_b  = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if ({s32_out_valid, s32_result, s32_c, s32_o, s32_z, s32_in_ready} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL reset32: got valid=%b res=%h c=%b o=%b z=%b rdy=%b want valid=0 res=0 c=0 o=0 z=1 rdy=1",
                     s32_out_valid, s32_result, s32_c, s32_o, s32_z, s32_in_ready);
        end
        checks++;
        if ({s8_out_valid, s8_result, s8_c, s8_o, s8_z, s8_in_ready} !== {1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL reset8: got valid=%b res=%h c=%b o=%b z=%b rdy=%b want valid=0 res=0 c=0 o=0 z=1 rdy=1",
                     s8_out_valid, s8_result, s8_c, s8_o, s8_z, s8_in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add_overflow();
        exp_t e;
        s32_out_ready = 1'b1;
        issue32(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        checks++;
        if (s32_out_valid !== 1'b1) begin
            failures++;
            $display("FAIL add_valid: got out_valid=%b want 1", s32_out_valid);
        end
        e = sb32.pop_front();
        checks++;
        if ({s32_result, s32_c, s32_o, s32_z} !== {e.res, e.c, e.o, e.z}) begin
            failures++;
            $display("FAIL add_model: got res=%h c=%b o=%b z=%b want res=%h c=%b o=%b z=%b",
                     s32_result, s32_c, s32_o, s32_z, e.res, e.c, e.o, e.z);
        end
        checks++;
        if ({s32_result, s32_c, s32_o, s32_z} !== {32'h8000_0000, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL add_const: got res=%h c=%b o=%b z=%b want res=80000000 c=0 o=1 z=0",
                     s32_result, s32_c, s32_o, s32_z);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [3:0]  cmd;
        logic [31:0] a, b;
        s32_out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i == 0)      begin cmd = OP_SUB; a = 32'd5;         b = 32'd5; end
            else if (i == 1) begin cmd = OP_SLT; a = 32'h8000_0000; b = 32'd1; end
            else begin
                cmd = 4'($urandom_range(0, 15));
                if (cmd == OP_MUL) cmd = OP_SRA;
                a = $urandom;
                b = $urandom;
            end
            checks++;
            if (s32_in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready[%0d]: got in_ready=%b want 1", i, s32_in_ready);
            end
            s32_in_valid = 1'b1; s32_cmd = cmd; s32_a = a; s32_b = b;
            sb32.push_back(model(32, cmd, a, b));
            @(posedge clk); #1;
            checks++;
            if (s32_out_valid !== 1'b1) begin
                failures++;
                $display("FAIL b2b_valid[%0d]: got out_valid=%b want 1", i, s32_out_valid);
            end
            e = sb32.pop_front();
            checks++;
            if ({s32_result, s32_c, s32_o, s32_z} !== {e.res, e.c, e.o, e.z}) begin
                failures++;
                $display("FAIL b2b_model[%0d] cmd=%0d a=%h b=%h: got res=%h c=%b o=%b z=%b want res=%h c=%b o=%b z=%b",
                         i, cmd, a, b, s32_result, s32_c, s32_o, s32_z, e.res, e.c, e.o, e.z);
            end
            if (i == 0) begin
                checks++;
                if ({s32_result, s32_c, s32_z} !== {32'd0, 1'b1, 1'b1}) begin
                    failures++;
                    $display("FAIL sub_const: got res=%h c=%b z=%b want res=0 c=1 z=1", s32_result, s32_c, s32_z);
                end
            end
            if (i == 1) begin
                checks++;
                if ({s32_result, s32_z} !== {32'd1, 1'b0}) begin
                    failures++;
                    $display("FAIL slt_const: got res=%h z=%b want res=1 z=0", s32_result, s32_z);
                end
            end
        end
        s32_in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (s32_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: got out_valid=%b want 0", s32_out_valid);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        s32_out_ready = 1'b0;
        issue32(OP_ADD, 32'd3, 32'd4);
        s32_in_valid = 1'b1; s32_cmd = OP_SUB; s32_a = 32'd10; s32_b = 32'd3;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (s32_out_valid !== 1'b1 || s32_in_ready !== 1'b0 || s32_result !== 32'd7) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got valid=%b rdy=%b res=%h want valid=1 rdy=0 res=7",
                         k, s32_out_valid, s32_in_ready, s32_result);
            end
            @(posedge clk); #1;
        end
        e = sb32.pop_front();
        checks++;
        if ({s32_out_valid, s32_result, s32_c, s32_o, s32_z} !== {1'b1, e.res, e.c, e.o, e.z}) begin
            failures++;
            $display("FAIL bp_stalled: got valid=%b res=%h c=%b o=%b z=%b want valid=1 res=%h c=%b o=%b z=%b",
                     s32_out_valid, s32_result, s32_c, s32_o, s32_z, e.res, e.c, e.o, e.z);
        end
        s32_out_ready = 1'b1;
        #1;
        checks++;
        if (s32_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_rise: got in_ready=%b want 1", s32_in_ready);
        end
        sb32.push_back(model(32, OP_SUB, 32'd10, 32'd3));
        @(posedge clk); #1;
        s32_in_valid = 1'b0;
        e = sb32.pop_front();
        checks++;
        if ({s32_out_valid, s32_result, s32_c, s32_o, s32_z} !== {1'b1, e.res, e.c, e.o, e.z} || s32_result !== 32'd7 - 32'd0 + 32'd0 && s32_result !== e.res) begin
            failures++;
            $display("FAIL bp_second: got valid=%b res=%h c=%b o=%b z=%b want valid=1 res=%h c=%b o=%b z=%b",
                     s32_out_valid, s32_result, s32_c, s32_o, s32_z, e.res, e.c, e.o, e.z);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ops8();
        exp_t       e;
        logic [3:0] cmds [6] = '{OP_SRA, OP_SRL, OP_SLTU, OP_SLL, OP_ADD, OP_SUB};
        logic [7:0] as   [6] = '{8'h90, 8'h90, 8'h01, 8'h90, 8'h7F, 8'h00};
        logic [7:0] bs   [6] = '{8'h0B, 8'h0B, 8'hFF, 8'h0B, 8'h01, 8'h01};
        logic [7:0] want [6] = '{8'hF2, 8'h12, 8'h01, 8'h80, 8'h80, 8'hFF};
        s8_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            issue8(cmds[i], as[i], bs[i]);
            e = sb8.pop_front();
            checks++;
            if ({s8_out_valid, s8_result, s8_c, s8_o, s8_z} !== {1'b1, e.res[7:0], e.c, e.o, e.z}) begin
                failures++;
                $display("FAIL ops8_model[%0d] cmd=%0d: got valid=%b res=%h c=%b o=%b z=%b want valid=1 res=%h c=%b o=%b z=%b",
                         i, cmds[i], s8_out_valid, s8_result, s8_c, s8_o, s8_z, e.res[7:0], e.c, e.o, e.z);
            end
            checks++;
            if (s8_result !== want[i]) begin
                failures++;
                $display("FAIL ops8_const[%0d]: got res=%h want %h", i, s8_result, want[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        exp_t       e;
        int         lat;
        logic [7:0] ma [3] = '{8'hFF, 8'h10, 8'hA7};
        logic [7:0] mb [3] = '{8'hFF, 8'h10, 8'h3C};
        s8_out_ready = 1'b1;
        issue8(OP_MUL, 8'd13, 8'd11);
        lat = 0;
        while (s8_out_valid !== 1'b1 && lat < 40) begin
            checks++;
            if (s8_in_ready !== 1'b0) begin
                failures++;
                $display("FAIL mul_busy_ready[%0d]: got in_ready=%b want 0", lat, s8_in_ready);
            end
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat != 8) begin
            failures++;
            $display("FAIL mul_latency: got %0d cycles after accept want 8", lat);
        end
        e = sb8.pop_front();
        checks++;
        if ({s8_result, s8_c, s8_o, s8_z} !== {e.res[7:0], e.c, e.o, e.z} || s8_result !== 8'h8F) begin
            failures++;
            $display("FAIL mul_13x11: got res=%h c=%b o=%b z=%b want res=8f c=%b o=%b z=%b",
                     s8_result, s8_c, s8_o, s8_z, e.c, e.o, e.z);
        end
        for (int i = 0; i < 3; i++) begin
            issue8(OP_MUL, ma[i], mb[i]);
            lat = 0;
            while (s8_out_valid !== 1'b1 && lat < 40) begin
                @(posedge clk); #1; lat++;
            end
            e = sb8.pop_front();
            checks++;
            if (lat != 8 || {s8_result, s8_c, s8_o, s8_z} !== {e.res[7:0], e.c, e.o, e.z}) begin
                failures++;
                $display("FAIL mul_model[%0d]: got lat=%0d res=%h c=%b o=%b z=%b want lat=8 res=%h c=%b o=%b z=%b",
                         i, lat, s8_result, s8_c, s8_o, s8_z, e.res[7:0], e.c, e.o, e.z);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mul();
        exp_t e;
        logic seen;
        s8_out_ready = 1'b1;
        issue8(OP_MUL, 8'h37, 8'h5A);
        sb8.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({s8_out_valid, s8_result, s8_c, s8_o, s8_z} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL rst_mid_mul: got valid=%b res=%h c=%b o=%b z=%b want valid=0 res=0 c=0 o=0 z=1",
                     s8_out_valid, s8_result, s8_c, s8_o, s8_z);
        end
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (s8_out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_pulse: got out_valid pulse=%b want 0", seen);
        end
        rst_n = 1'b1;
        s8_in_valid = 1'b1; s8_cmd = OP_ADD; s8_a = 8'h20; s8_b = 8'h22;
        #1;
        checks++;
        if (s8_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_ready_after: got in_ready=%b want 1", s8_in_ready);
        end
        sb8.push_back(model(8, OP_ADD, 32'h20, 32'h22));
        @(posedge clk); #1;
        s8_in_valid = 1'b0;
        e = sb8.pop_front();
        checks++;
        if ({s8_out_valid, s8_result, s8_c, s8_o, s8_z} !== {1'b1, e.res[7:0], e.c, e.o, e.z}) begin
            failures++;
            $display("FAIL rst_first_op: got valid=%b res=%h c=%b o=%b z=%b want valid=1 res=%h c=%b o=%b z=%b",
                     s8_out_valid, s8_result, s8_c, s8_o, s8_z, e.res[7:0], e.c, e.o, e.z);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_backpressure();
        test_ops8();
        test_mul();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
